ais_frame_arbiter: RTL

AIS_FRAME_ARBITER -- requirements
Module: ais_frame_arbiter

---
 rtl/ais_frame_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ais_frame_arbiter.sv
// Two-channel AIS frame arbiter: grants one I/Q stream to the shared decoder
// for a fixed number of beats, then enforces an idle guard gap.
module ais_frame_arbiter #(
    parameter int PAR_DATA_WIDTH   = 16,
    parameter int PAR_FRAME_LENGTH = 256,
    parameter int PAR_GUARD_LENGTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        s0_axis_tvalid,
    input  logic [2*PAR_DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                        s0_axis_tuser,
    input  logic                        s1_axis_tvalid,
    input  logic [2*PAR_DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                        s1_axis_tuser,
    output logic                        m_axis_tvalid,
    output logic [2*PAR_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic [1:0]                  o_grant,
    output logic                        o_busy,
    input  logic                        i_drop_clr,
    output logic [15:0]                 o_drop_cnt
);

    localparam int LP_W = 2 * PAR_DATA_WIDTH;
    localparam logic [15:0] LP_FLAST = 16'(PAR_FRAME_LENGTH);
    localparam logic [15:0] LP_GLAST =
        (PAR_GUARD_LENGTH > 0) ? 16'(PAR_GUARD_LENGTH - 1) : 16'd0;
    localparam logic LP_ONE_BEAT = (PAR_FRAME_LENGTH == 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam state_t LP_AFTER =
        (PAR_GUARD_LENGTH > 0) ? ST_GUARD : ST_IDLE;

    state_t r_state;
    state_t w_state_nx;

    logic [15:0]     r_beat;
    logic [15:0]     r_gcnt;
    logic            r_owner;
    logic            r_last;
    logic            r_tvalid;
    logic [LP_W-1:0] r_tdata;
    logic            r_tuser;
    logic            r_tlast;
    logic [1:0]      r_grant;
    logic            r_busy;
    logic [15:0]     r_drop;

    logic            w_ev0;
    logic            w_ev1;
    logic            w_pick;
    logic            w_own_valid;
    logic            w_own_ev;
    logic            w_oth_ev;
    logic [LP_W-1:0] w_own_data;
    logic            w_fwd_end;

    logic            w_tvalid;
    logic [LP_W-1:0] w_tdata;
    logic            w_tuser;
    logic            w_tlast;
    logic [1:0]      w_grant;
    logic            w_busy;
    logic [1:0]      w_drops;
    logic [15:0]     w_beat_nx;
    logic            w_owner_nx;
    logic            w_last_nx;
    logic [16:0]     w_dsum;

    assign w_ev0 = s0_axis_tvalid & s0_axis_tuser;
    assign w_ev1 = s1_axis_tvalid & s1_axis_tuser;

    // On a tie the channel that did not win last time takes the grant.
    assign w_pick = (w_ev0 & w_ev1) ? ~r_last : w_ev1;

    assign w_own_valid = r_owner ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_own_data  = r_owner ? s1_axis_tdata  : s0_axis_tdata;
    assign w_own_ev    = r_owner ? w_ev1 : w_ev0;
    assign w_oth_ev    = r_owner ? w_ev0 : w_ev1;
    assign w_fwd_end   = w_own_valid & (r_beat == LP_FLAST - 16'd1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ev0 | w_ev1) begin
                    w_state_nx = LP_ONE_BEAT ? LP_AFTER : ST_FWD;
                end
            end
            ST_FWD: begin
                if (w_fwd_end) begin
                    w_state_nx = LP_AFTER;
                end
            end
            ST_GUARD: begin
                if (r_gcnt == LP_GLAST) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tvalid   = 1'b0;
        w_tdata    = r_tdata;
        w_tuser    = 1'b0;
        w_tlast    = 1'b0;
        w_grant    = 2'b00;
        w_busy     = 1'b0;
        w_drops    = 2'd0;
        w_beat_nx  = r_beat;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ev0 | w_ev1) begin
                    w_tvalid   = 1'b1;
                    w_tdata    = w_pick ? s1_axis_tdata : s0_axis_tdata;
                    w_tuser    = 1'b1;
                    w_tlast    = LP_ONE_BEAT;
                    w_grant    = w_pick ? 2'b10 : 2'b01;
                    w_busy     = 1'b1;
                    w_drops    = {1'b0, w_ev0 & w_ev1};
                    w_beat_nx  = 16'd1;
                    w_owner_nx = w_pick;
                    w_last_nx  = w_pick;
                end
            end
            ST_FWD: begin
                w_busy  = 1'b1;
                w_grant = r_owner ? 2'b10 : 2'b01;
                w_drops = {1'b0, w_oth_ev} + {1'b0, w_own_ev};
                if (w_own_valid) begin
                    w_tvalid  = 1'b1;
                    w_tdata   = w_own_data;
                    w_tlast   = w_fwd_end;
                    w_beat_nx = r_beat + 16'd1;
                end
            end
            ST_GUARD: begin
                w_busy  = 1'b1;
                w_drops = {1'b0, w_ev0} + {1'b0, w_ev1};
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign w_dsum = {1'b0, r_drop} + {15'd0, w_drops};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_grant  <= 2'b00;
            r_busy   <= 1'b0;
            r_beat   <= 16'd0;
            r_gcnt   <= 16'd0;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_drop   <= 16'd0;
        end else begin
            r_tvalid <= w_tvalid;
            r_tdata  <= w_tdata;
            r_tuser  <= w_tuser;
            r_tlast  <= w_tlast;
            r_grant  <= w_grant;
            r_busy   <= w_busy;
            r_beat   <= w_beat_nx;
            r_owner  <= w_owner_nx;
            r_last   <= w_last_nx;
            r_gcnt   <= (r_state == ST_GUARD) ? r_gcnt + 16'd1 : 16'd0;
            if (i_drop_clr) begin
                r_drop <= 16'd0;
            end else if (w_dsum[16]) begin
                r_drop <= 16'hFFFF;
            end else begin
                r_drop <= w_dsum[15:0];
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign o_grant       = r_grant;
    assign o_busy        = r_busy;
    assign o_drop_cnt    = r_drop;

endmodule
